// File: rtl/jtframe_prog_pkg.sv
// Shared types and constants for the ROM download feeder.
// Contents: the FSM state enum, the FIFO entry layout and the
// active-low SDRAM byte-lane masks.
package jtframe_prog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [21:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  // Masks are active-low: a 0 enables the lane.
  localparam logic [1:0] MASK_LO   = 2'b10;
  localparam logic [1:0] MASK_HI   = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;

  // Odd byte addresses land in the upper lane of the 16-bit SDRAM word.
  function automatic logic [1:0] lane_mask(input logic a0);
    return a0 ? MASK_HI : MASK_LO;
  endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Small synchronous byte FIFO between the ioctl side and the SDRAM
// write pacer.
// Ports:
//   clk_rom, rst_n  clock and synchronous active-low reset
//   push, din       write request and entry
//   pop             read request (advances read pointer)
//   full, empty     status flags
//   dout            head entry (valid while !empty, read combinationally)
// A push while full is accepted only when a pop happens in the same cycle.
module jtframe_prog_fifo
  import jtframe_prog_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_rom,
  input  logic        rst_n,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output fifo_entry_t dout
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_do_pop;
  logic        w_do_push;

  // Extra MSB on each pointer separates full from empty.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign dout = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_rom) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jtframe_prog_feeder.sv
// ROM download feeder: buffers ioctl bytes from the HPS and replays them
// to the SDRAM controller as paced single-byte writes.
// Ports:
//   clk_rom, rst_n                     clock, synchronous active-low reset
//   downloading, ioctl_addr/data/wr    HPS download stream
//   prog_addr/data/mask, prog_we       SDRAM write port (word addr, byte lane)
//   loader_busy                        high while loading or draining
//   overflow                           sticky, a byte was dropped on a full FIFO
//   dwnld_done                         one-cycle pulse after the last write
// Build option: define JTFRAME_ROM_HEADER_EN to strip HEADER_LEN leading
// bytes from the image and rebase the remaining addresses to zero.
//
// state    | meaning
// ---------+------------------------------------------------------
// ST_IDLE  | no download; waiting for downloading to rise
// ST_LOAD  | HPS streaming; bytes buffered and written out
// ST_DRAIN | stream ended; flushing the FIFO and the last gap
// ST_DONE  | single cycle; dwnld_done asserted
module jtframe_prog_feeder
  import jtframe_prog_pkg::*;
#(
  parameter int PROG_GAP   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int HEADER_LEN = 16
) (
  input  logic        clk_rom,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  output logic        loader_busy,
  output logic        overflow,
  output logic        dwnld_done
);

`ifdef JTFRAME_ROM_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_gap;
  logic [21:0] r_prog_addr;
  logic [7:0]  r_prog_data;
  logic [1:0]  r_prog_mask;
  logic        r_prog_we;
  logic        r_overflow;

  logic        w_keep;
  logic [21:0] w_byte_addr;
  logic        w_push_req;
  logic        w_pop;
  logic        w_drop;
  logic        w_full;
  logic        w_empty;
  logic        w_gap_zero;
  fifo_entry_t w_din;
  fifo_entry_t w_dout;

  // With the header option off HDR_EN is constant 0 and this reduces to a
  // straight pass-through of the ioctl address.
  assign w_keep      = !(HDR_EN && (ioctl_addr < 22'(HEADER_LEN)));
  assign w_byte_addr = HDR_EN ? (ioctl_addr - 22'(HEADER_LEN)) : ioctl_addr;

  assign w_push_req = downloading && ioctl_wr && w_keep;
  assign w_gap_zero = (r_gap == 8'd0);
  assign w_pop      = !w_empty && w_gap_zero;
  // A full FIFO still takes the byte if the head leaves in the same cycle.
  assign w_drop     = w_push_req && w_full && !w_pop;

  assign w_din.addr = w_byte_addr;
  assign w_din.data = ioctl_data;

  jtframe_prog_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_rom (clk_rom),
    .rst_n   (rst_n),
    .push    (w_push_req),
    .din     (w_din),
    .pop     (w_pop),
    .full    (w_full),
    .empty   (w_empty),
    .dout    (w_dout)
  );

  always_ff @(posedge clk_rom) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    loader_busy = 1'b0;
    dwnld_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (downloading) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        loader_busy = 1'b1;
        if (!downloading) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        loader_busy = 1'b1;
        if (w_empty && w_gap_zero) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        dwnld_done  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Write pacer: a pop registers the SDRAM outputs and restarts the gap
  // counter, so consecutive prog_we pulses are PROG_GAP cycles apart.
  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      r_gap       <= 8'd0;
      r_prog_addr <= '0;
      r_prog_data <= '0;
      r_prog_mask <= MASK_NONE;
      r_prog_we   <= 1'b0;
    end else begin
      r_prog_we <= 1'b0;
      if (w_pop) begin
        r_prog_we   <= 1'b1;
        r_prog_addr <= {1'b0, w_dout.addr[21:1]};
        r_prog_data <= w_dout.data;
        r_prog_mask <= lane_mask(w_dout.addr[0]);
        r_gap       <= 8'(PROG_GAP - 1);
      end else if (!w_gap_zero) begin
        r_gap <= r_gap - 8'd1;
      end
    end
  end

  // A drop in the very cycle a new download starts belongs to the new
  // download, so setting wins over clearing.
  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (r_state == ST_IDLE && downloading) begin
      r_overflow <= 1'b0;
    end
  end

  assign prog_addr = r_prog_addr;
  assign prog_data = r_prog_data;
  assign prog_mask = r_prog_mask;
  assign prog_we   = r_prog_we;
  assign overflow  = r_overflow;

endmodule

// File: doc/jtframe_prog_feeder.md
JTFRAME_PROG_FEEDER -- requirements
Module: jtframe_prog_feeder

Interface
REQ-001 Parameter PROG_GAP, default 8: minimum clk_rom cycles from one prog_we pulse to the next (range 2..255).
REQ-002 Parameter FIFO_DEPTH, default 4: byte FIFO entries, power of two, range 2..16.
REQ-003 Parameter HEADER_LEN, default 16: header bytes skipped; used only with JTFRAME_ROM_HEADER_EN.
REQ-004 clk_rom  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 downloading  in  1  high while the HPS streams a ROM.
REQ-007 ioctl_addr  in  22  byte address of the current ioctl byte.
REQ-008 ioctl_data  in  8  ioctl byte.
REQ-009 ioctl_wr  in  1  one-cycle strobe; byte valid.
REQ-010 prog_addr  out  22  SDRAM word address.
REQ-011 prog_data  out  8  byte to write.
REQ-012 prog_mask  out  2  active-low byte-lane mask.
REQ-013 prog_we  out  1  one-cycle write strobe to the SDRAM controller.
REQ-014 loader_busy  out  1  high in LOAD or DRAIN.
REQ-015 overflow  out  1  sticky; a byte was dropped.
REQ-016 dwnld_done  out  1  one-cycle pulse; the last byte has been written.

Function
REQ-017 FSM states IDLE, LOAD, DRAIN, DONE: IDLE->LOAD on downloading=1; LOAD->DRAIN on downloading=0; DRAIN->DONE when FIFO empty and gap counter zero; DONE->IDLE next cycle.
REQ-018 ioctl_wr with downloading=1 pushes {ioctl_addr, ioctl_data} into the FIFO in any state; ioctl_wr with downloading=0 is ignored.
REQ-019 Pop occurs when FIFO is non-empty and the gap counter is zero; prog_we goes high the cycle after the pop, for exactly one cycle, and the gap counter loads PROG_GAP-1.
REQ-020 Mapping: prog_addr = {1'b0, byte_addr[21:1]}; prog_data = byte; prog_mask = byte_addr[0] ? 2'b01 : 2'b10.
REQ-021 prog_addr, prog_data and prog_mask hold their values from one prog_we until the next.
REQ-022 Minimum latency: ioctl_wr in cycle N into an empty FIFO with gap zero gives prog_we in cycle N+2.
REQ-023 Push when full with no pop in the same cycle: byte dropped, overflow set.
REQ-024 Push when full with a pop in the same cycle: push accepted, overflow unchanged.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH, with one extra bit for the full/empty distinction.
REQ-026 overflow clears on the IDLE->LOAD transition.
REQ-027 dwnld_done is high exactly in the DONE cycle.
REQ-028 downloading rising during DRAIN: finish the drain and pulse dwnld_done, then IDLE->LOAD; bytes pushed meanwhile are retained.

Reset
REQ-029 rst_n=0 in any state, including mid-download, clears the state to IDLE, FIFO pointers, gap counter, prog_addr, prog_data, prog_we, overflow and dwnld_done to 0, and sets prog_mask to 2'b11; it discards buffered bytes.

Configuration
REQ-030 With JTFRAME_ROM_HEADER_EN defined, bytes with ioctl_addr < HEADER_LEN are not pushed, and the remaining bytes use byte_addr = ioctl_addr - HEADER_LEN.
REQ-031 Without JTFRAME_ROM_HEADER_EN, every byte is pushed with byte_addr = ioctl_addr, and HEADER_LEN has no effect.

Structure
REQ-032 Package jtframe_prog_pkg holds the FSM state enum, the FIFO entry struct {addr[21:0], data[7:0]}, and mask constants MASK_LO=2'b10, MASK_HI=2'b01, MASK_NONE=2'b11.
REQ-033 The FIFO is a sub-module jtframe_prog_fifo (push, pop, full, empty, dout), one clock, the same rst_n.

Verification
REQ-034 Bytes 0x11 at addr 0 and 0x22 at addr 1, spaced 20 cycles -> prog_we at N+2 with addr 0, mask 2'b10, data 0x11; then addr 0, mask 2'b01, data 0x22.
REQ-035 Six back-to-back ioctl_wr, FIFO_DEPTH=4, PROG_GAP=8 -> first byte popped at once, four bytes buffered, sixth dropped, overflow=1; prog_we exactly 8 cycles apart.
REQ-036 downloading falls with 3 bytes buffered -> state DRAIN, loader_busy=1, three prog_we, then dwnld_done for one cycle and loader_busy=0.
REQ-037 rst_n low for 1 cycle with 2 bytes buffered -> no further prog_we, all outputs at reset values, next download starts cleanly.
REQ-038 JTFRAME_ROM_HEADER_EN, HEADER_LEN=16, bytes at addr 0..17 -> only two prog_we: addr 0 mask 2'b10, then addr 0 mask 2'b01.
